// File: rtl/sr_mon_pkg.sv
// Shared types and constants for the SR flip-flop protocol monitor.
// The monitor's optional complement check is enabled with SR_MON_COMPL_CHECK_EN.
package sr_mon_pkg;

   localparam int unsigned CNT_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      TRACK = 2'd1,
      UNDEF = 2'd2
   } state_t;

   // Model step for one rising edge; the rules do not depend on the current state.
   function automatic state_t next_state(input state_t cur, input logic s, input logic r);
      state_t nxt;
      nxt = cur;
      unique case ({s, r})
         2'b01:   nxt = TRACK;
         2'b10:   nxt = TRACK;
         2'b11:   nxt = UNDEF;
         default: nxt = cur;
      endcase
      return nxt;
   endfunction

   function automatic logic next_pred(input logic cur, input logic s, input logic r);
      logic nxt;
      nxt = cur;
      unique case ({s, r})
         2'b01:   nxt = 1'b0;
         2'b10:   nxt = 1'b1;
         default: nxt = cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/sr_mon_sat_cnt.sv
// Saturating up-counter with increment enable and asynchronous active-high reset.
module sr_mon_sat_cnt
   import sr_mon_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             at_max;

   assign at_max = &cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && !at_max) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/sr_ff_monitor.sv
// Cycle-accurate checker for a clocked SR flip-flop: predicts q and flags mismatches.
// Define SR_MON_COMPL_CHECK_EN to also require q_bar == ~q on every compare.
module sr_ff_monitor
   import sr_mon_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             s,
   input  logic             r,
   input  logic             q,
   input  logic             q_bar,
   output logic             exp_q,
   output logic [1:0]       state,
   output logic             err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] illegal_cnt,
   output logic [CNT_W-1:0] check_cnt
);

   state_t state_q, state_d;
   logic   pred_q, pred_d;
   logic   err_q, err_d;
   logic   sticky_q, sticky_d;
   logic   compare;
   logic   mismatch;
   logic   illegal;

   // The model follows s/r whether or not checking is enabled.
   always_comb begin
      state_d = next_state(state_q, s, r);
      pred_d  = next_pred(pred_q, s, r);
   end

   assign compare = en && (state_q == TRACK);
   assign illegal = en && s && r;

`ifdef SR_MON_COMPL_CHECK_EN
   // Either fault folds into one mismatch so a bad edge is counted once.
   assign mismatch = (q != pred_q) || (q_bar == q);
`else
   logic unused_q_bar;
   assign unused_q_bar = q_bar;
   assign mismatch     = (q != pred_q);
`endif

   always_comb begin
      err_d    = compare && mismatch;
      sticky_d = sticky_q || err_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= INIT;
         pred_q   <= 1'b0;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pred_q   <= pred_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
      end
   end

   sr_mon_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_err_cnt (
      .clk (clk),
      .rst (rst),
      .inc (err_d),
      .cnt (err_cnt)
   );

   sr_mon_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_illegal_cnt (
      .clk (clk),
      .rst (rst),
      .inc (illegal),
      .cnt (illegal_cnt)
   );

   sr_mon_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_check_cnt (
      .clk (clk),
      .rst (rst),
      .inc (compare),
      .cnt (check_cnt)
   );

   assign exp_q      = pred_q;
   assign state      = state_q;
   assign err        = err_q;
   assign err_sticky = sticky_q;

endmodule

// File: doc/sr_ff_monitor.md
# sr_ff_monitor

Synthesizable protocol monitor for a clocked SR flip-flop. It observes the flip-flop's `s`/`r` inputs and its `q`/`q_bar` outputs on the shared clock. A cycle-accurate reference model predicts `q`, and the monitor flags any mismatch or illegal `s=r=1` request. It is the checking end of the SR flip-flop's stimulus interface and sits beside the device under test in benches and on-chip debug builds.

## Interface
Parameters:
- `CNT_W`, default 8: width of every saturating counter.

Ports:
- `clk`, in, 1: single clock, rising-edge active.
- `rst`, in, 1: asynchronous, active-high reset.
- `en`, in, 1: enables checking and counting. The model tracks regardless of `en`.
- `s`, in, 1: set input, tapped from the monitored flip-flop.
- `r`, in, 1: reset input, tapped from the monitored flip-flop.
- `q`, in, 1: true output of the monitored flip-flop.
- `q_bar`, in, 1: complement output of the monitored flip-flop.
- `exp_q`, out, 1: model's predicted `q`.
- `state`, out, 2: current FSM state encoding.
- `err`, out, 1: one-cycle pulse on a failed compare.
- `err_sticky`, out, 1: set by any `err`; cleared only by `rst`.
- `err_cnt`, out, `CNT_W`: saturating count of failed compares.
- `illegal_cnt`, out, `CNT_W`: saturating count of edges with `en & s & r`.
- `check_cnt`, out, `CNT_W`: saturating count of compares performed.

## Operation
FSM states:
- INIT (2'd0): model unknown, no compares.
- TRACK (2'd1): model valid, compares active.
- UNDEF (2'd2): model unknown after `s=r=1`.

Transitions, evaluated on every rising edge using `s`/`r` sampled at that edge:
- `01`: go to TRACK with `exp_q` <= 0.
- `10`: go to TRACK with `exp_q` <= 1.
- `11`: go to UNDEF. `exp_q` holds its value.
- `00`: hold state and `exp_q`.
- The rules are identical from every state.

Compare rules:
- A compare happens on an edge only when the state before the edge is TRACK and `en=1`.
- The compare checks sampled `q` against the current `exp_q`, which was predicted at the previous edge.
- Compare and transition occur on the same edge. An edge that leaves TRACK still performs its compare.
- Mismatch: `err` pulses high for one cycle, `err_sticky` is set, and `err_cnt` is incremented.
- Every compare increments `check_cnt`.

Counter rules:
- `illegal_cnt` increments on any edge with `en=1` and `s=r=1`, in any state.
- All counters saturate at 2^`CNT_W`-1 and never wrap.

Reset:
- Reset is asynchronous at any time, including mid-sequence.
- Reset values: state=INIT, `exp_q`=0, `err`=0, `err_sticky`=0, all counters 0.
- The first edge after reset deassertion is evaluated normally.

## Timing
- Latency: `exp_q` is registered and valid one cycle after the setting edge.
- A DUT error at edge N appears on `err` after edge N+1.
- `err` is registered, high for exactly one cycle per failed compare. It is never held across cycles.
- When `en` deasserts, counts and errors are suppressed from that edge on. The model keeps tracking, so re-enabling needs no resync.
- Counter updates are visible the cycle after the triggering edge.

## Configuration
- `SR_MON_COMPL_CHECK_EN` defined:
  - Each compare also requires `q_bar == ~q`.
  - Either failure produces a single `err` pulse and a single `err_cnt` increment, never two.
- `SR_MON_COMPL_CHECK_EN` undefined:
  - `q_bar` is ignored. The port remains but is unused.

## Structure
- Package `sr_mon_pkg` holds:
  - the state typedef (`INIT`, `TRACK`, `UNDEF`) and its 2-bit encoding;
  - the `CNT_W` default constant.
- Sub-module `sr_mon_sat_cnt` is a parameterized saturating counter with increment enable and asynchronous reset. It is instantiated three times.

## Test plan
- Sequence `00, 01, 10, 11, 00, 10, 01, 11` (one per clock, correct DUT, `en=1`):
  - state visits INIT, INIT, TRACK, TRACK, UNDEF, UNDEF, TRACK, TRACK, then UNDEF;
  - final counts: `check_cnt`=4, `illegal_cnt`=2, `err_cnt`=0, `err_sticky`=0.
- Apply `10`, force `q=0` on the next edge:
  - `err` pulses once, `err_cnt`=1, `err_sticky`=1;
  - restore `q`, apply `00` for 5 cycles: no further `err`, `check_cnt`=6.
- Same sequence as the first scenario with `en=0`:
  - all counters stay 0 and `err` never asserts;
  - `exp_q` and `state` still follow the model.
- Assert `rst` asynchronously mid-TRACK with counters nonzero:
  - all outputs return to reset values immediately, before the next edge;
  - state=INIT.
- `CNT_W=2`, hold `s=r=1` for 6 enabled edges:
  - `illegal_cnt` stops at 3 with no wrap.
- With `SR_MON_COMPL_CHECK_EN`, in TRACK with correct `q`, force `q_bar=q`:
  - `err` pulses once, `err_cnt`=1;
  - without the macro: no error.
